cache_fill_fsm: RTL
===================

# cache_fill_fsm

Initiator-side controller for the multi-cycle memory (`memory4c`): on a cache miss it fetches one 16-byte block, eight 16-bit words, with pipelined reads. It issues one read per cycle, collects the returns via `data_valid`, and drives the cache data-array and tag-array write strobes. It sits between the I/D cache control logic and the shared `memory4c` instance.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte address width; must match `memory4c`.
- `WORDS_PER_BLOCK`, fixed 8: not overridable; block is 16 bytes.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `miss_detected`  in  1  miss request from cache; sampled only in IDLE.
- `miss_address`  in  ADDR_WIDTH  byte address of missing access; latched on accept.
- `memory_data`  in  16  read data from memory.
- `memory_data_valid`  in  1  memory return strobe.
- `mem_enable`  out  1  read request to memory; `wr` to memory tied 0 by the parent.
- `mem_addr`  out  ADDR_WIDTH  word-aligned read address; bit 0 always 0.
- `fsm_busy`  out  1  fill in progress.
- `write_data_array`  out  1  write `fill_data` into data array word `fill_word_sel`.
- `fill_word_sel`  out  3  word index within block for the current write.
- `fill_data`  out  16  equals `memory_data`.
- `write_tag_array`  out  1  write tag/valid for latched block; one-cycle pulse.

## Operation
- States:
  - IDLE:
    - `miss_detected`=1 at a posedge latches `base = miss_address[ADDR_WIDTH-1:4]`, clears counters and moves to FILL.
    - `memory_data_valid` is ignored in IDLE.
  - FILL:
    - Issue counter `iss` (4 bits) runs 0..8. Receive counter `rcv` (4 bits) runs 0..8.
    - `mem_enable = (iss < 8)`.
    - `mem_addr = {base, word(iss), 1'b0}`.
    - `iss` increments each cycle while < 8. There is no backpressure: memory accepts one read per cycle.
    - On `memory_data_valid & (rcv < 8)`: `write_data_array`=1, `fill_word_sel = word(rcv)`, `rcv` increments.
    - When `rcv` reaches 8 (i.e. the 8th data write): `write_tag_array`=1 in the same cycle, and the next state is IDLE.
    - Valids beyond the 8th are ignored.
    - `miss_detected` is ignored throughout FILL.
- `word(n) = n[2:0]` by default; see Configuration.
- `fsm_busy = (state == FILL)`.
- All outputs are combinational decodes of state, counters, `base` and the memory inputs. There is no combinational path from `miss_detected`.
- Async reset: state to IDLE; `iss`, `rcv`, `base` and start offset cleared; all outputs 0. Memory responses still in flight after a reset are discarded because the block is in IDLE.

## Timing
- Memory read latency is 4 cycles: a request in cycle t returns valid in cycle t+4.
- Nominal fill, with the miss accepted at the posedge ending cycle 0:
  - cycles 1–8: `mem_enable`=1, words 0..7.
  - cycles 5–12: `write_data_array`=1.
  - cycle 12: `write_tag_array`=1.
  - `fsm_busy`=1 in cycles 1–12.
  - cycle 13: IDLE.
- Fill occupancy is 12 cycles.
- Back-to-back misses: the earliest next accept is the posedge ending cycle 13; the first new request goes out in cycle 14.
- Reset mid-fill: outputs drop to 0 immediately (asynchronously), with no tag write.
- Gaps in `memory_data_valid` are tolerated; FILL persists until 8 words have been received.

## Configuration
- `CACHE_FILL_CRITICAL_WORD_FIRST_EN`:
  - Defined: on accept, also latch `start = miss_address[3:1]`; then `word(n) = (start + n[2:0]) mod 8`. Issue and fill order both begin at the missed word and wrap.
  - Undefined: `start` does not exist; `word(n) = n[2:0]`, so the order is always 0..7.
- Latency and occupancy are identical in both builds.

## Test plan
- Basic fill: reset, then `miss_detected`=1 with `miss_address`=0x1236 for one cycle. Required:
  - `mem_addr` 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - 8 `write_data_array` pulses with `fill_word_sel` 0..7 and data matching memory contents.
  - `write_tag_array` pulse in cycle 12.
  - `fsm_busy` low in cycle 13.
- Miss held high: `miss_detected` held at 1 for 20 cycles at 0x0040. Required:
  - the second fill's first request appears in cycle 14 with `mem_addr`=0x0040.
  - no request addresses are issued in cycles 9–13.
- Reset mid-fill: assert `rst` in cycle 6 (asynchronously, mid-cycle). Required:
  - `fsm_busy`, `mem_enable` and `write_data_array` go to 0 before the next posedge.
  - no `write_tag_array` pulse.
  - stale valids after deassertion produce no writes.
- Spurious/extra valids: `memory_data_valid` pulsed in IDLE, and a 9th valid injected after the fill completes. Required: no `write_data_array` pulse for either.
- With `CACHE_FILL_CRITICAL_WORD_FIRST_EN`: miss at 0x00AA (word 5). Required:
  - `mem_addr` sequence 0xAA, 0xAC, 0xAE, 0xA0, 0xA2, 0xA4, 0xA6, 0xA8.
  - `fill_word_sel` sequence 5, 6, 7, 0, 1, 2, 3, 4.
  - tag write in cycle 12.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
`timescale 1ns/1ps
// Signal bundle between cache_fill_fsm, the cache control/arrays and memory4c.
// master = fill controller, slave = surrounding cache and memory.
interface cache_fill_fsm_if #(
    parameter int ADDR_WIDTH = 16
);
    // No ready signal anywhere: memory takes one read per cycle whenever mem_enable
    // is high, and memory_data_valid is a one-cycle strobe carrying one word.
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic [15:0]           memory_data;
    logic                  memory_data_valid;
    logic                  mem_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  fsm_busy;
    logic                  write_data_array;
    logic [2:0]            fill_word_sel;
    logic [15:0]           fill_data;
    logic                  write_tag_array;
    logic                  dbg_state;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output mem_enable, mem_addr, fsm_busy, write_data_array, fill_word_sel,
               fill_data, write_tag_array, dbg_state
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  mem_enable, mem_addr, fsm_busy, write_data_array, fill_word_sel,
               fill_data, write_tag_array, dbg_state
    );
endinterface

// File: rtl/cache_fill_fsm.sv
`timescale 1ns/1ps
// Cache miss fill controller: fetches one 16-byte block as eight pipelined 16-bit reads.
// Build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN makes issue and fill start at the missed word.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    cache_fill_fsm_if.master bus
);
    localparam logic [3:0] WORDS_PER_BLOCK = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            iss_q, iss_d;
    logic [3:0]            rcv_q, rcv_d;
    logic [ADDR_WIDTH-5:0] base_q, base_d;
    logic [2:0]            iss_word, rcv_word;
    logic                  issue_ok, recv_ok, last_recv;
    logic                  mem_enable, write_data_array, write_tag_array, fsm_busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [2:0]            fill_word_sel;
    logic                  unused_addr_lsbs;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [2:0] start_q, start_d;

    // 3-bit adds wrap naturally, giving the mod-8 word rotation.
    assign iss_word = start_q + iss_q[2:0];
    assign rcv_word = start_q + rcv_q[2:0];
`else
    assign iss_word = iss_q[2:0];
    assign rcv_word = rcv_q[2:0];
`endif

    assign unused_addr_lsbs = ^bus.miss_address[3:0];

    assign issue_ok  = (state_q == FILL) && (iss_q < WORDS_PER_BLOCK);
    assign recv_ok   = (state_q == FILL) && bus.memory_data_valid && (rcv_q < WORDS_PER_BLOCK);
    assign last_recv = recv_ok && (rcv_q == WORDS_PER_BLOCK - 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            iss_q   <= '0;
            rcv_q   <= '0;
            base_q  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            base_q  <= base_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start_q <= start_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        base_d  = base_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        start_d = start_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    state_d = FILL;
                    iss_d   = '0;
                    rcv_d   = '0;
                    base_d  = bus.miss_address[ADDR_WIDTH-1:4];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                    start_d = bus.miss_address[3:1];
`endif
                end
            end
            FILL: begin
                if (issue_ok) iss_d = iss_q + 4'd1;
                if (recv_ok) rcv_d = rcv_q + 4'd1;
                // Completion is driven by the 8th received word, never by issue.
                if (last_recv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fsm_busy         = (state_q == FILL);
        mem_enable       = 1'b0;
        mem_addr         = '0;
        write_data_array = 1'b0;
        fill_word_sel    = '0;
        write_tag_array  = last_recv;
        if (issue_ok) begin
            mem_enable = 1'b1;
            mem_addr   = {base_q, iss_word, 1'b0};
        end
        if (recv_ok) begin
            write_data_array = 1'b1;
            fill_word_sel    = rcv_word;
        end
    end

    assign bus.mem_enable       = mem_enable;
    assign bus.mem_addr         = mem_addr;
    assign bus.fsm_busy         = fsm_busy;
    assign bus.write_data_array = write_data_array;
    assign bus.fill_word_sel    = fill_word_sel;
    assign bus.fill_data        = bus.memory_data;
    assign bus.write_tag_array  = write_tag_array;
    assign bus.dbg_state        = state_q;
endmodule
